alu_writeback: RTL and testbench
================================

// Module: alu_writeback
// PURPOSE
//  Result-side consumer of the ALU: accepts one ALU result pair (Y1, Y2, compare_res) per transaction via valid/ready.
//  Writes it into the register file through a single write port, which holds one word per cycle.
//  A DOUBLE/dual-result transaction therefore takes two write cycles, Y1 first, then Y2.
//  Also holds the architectural compare-flag register. Sits between the ALU outputs and the register-file write arbiter.
// PARAMETERS
//  DATA_W      32  width of Y1/Y2 and register-file data
//  ADDR_W      5   register-file address width
//  FLAG_W      8   width of compare_res / flags
//  DROP_R0     1   1: writes to address 0 are discarded (hardwired zero register)
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  resetn      in   1       asynchronous active-low reset
//  in_valid    in   1       upstream presents a result transaction
//  in_ready    out  1       block accepts transaction this cycle
//  in_y1       in   DATA_W  ALU Y1
//  in_y2       in   DATA_W  ALU Y2
//  in_cmp      in   FLAG_W  ALU compare_res
//  in_dst1     in   ADDR_W  destination register for Y1
//  in_dst2     in   ADDR_W  destination register for Y2
//  in_wmask    in   2       bit0: write Y1, bit1: write Y2
//  in_setf     in   1       load flags from in_cmp
//  rf_we       out  1       write request to register file
//  rf_waddr    out  ADDR_W  write address
//  rf_wdata    out  DATA_W  write data
//  rf_ready    in   1       register file accepts the write this cycle
//  flags       out  FLAG_W  architectural compare flags
//  busy        out  1       state != IDLE
//  done        out  1       one-cycle pulse: transaction fully retired
// BEHAVIOUR
//  Accept = in_valid & in_ready. The block latches y1, y2, dst1, dst2 and an effective mask on the accepting edge.
//   Effective mask bit i = in_wmask[i] & !(DROP_R0 & dst_i==0).
//  States: IDLE, WR1, WR2. Transitions:
//   IDLE --accept--> WR1 if emask[0]; else WR2 if emask[1]; else IDLE.
//   WR1 --rf_ready--> WR2 if emask[1], else "finish". WR2 --rf_ready--> "finish".
//   finish: go to IDLE; if in_valid in that same cycle, accept instead and branch as from IDLE.
//   Back-to-back transactions therefore leave no bubble.
//  in_ready = resetn & (IDLE | (WR1 & rf_ready & !emask[1]) | (WR2 & rf_ready)). Combinational from rf_ready.
//  rf_we = 1 exactly in WR1/WR2, with rf_waddr/rf_wdata = latched dst/y of that state.
//   The request is held stable until rf_ready; otherwise rf_we = 0, addr/data = 0.
//  Write latency: the first rf_we is asserted the cycle after accept. Minimum 1 cycle per word.
//  flags: loaded with in_cmp on the accepting edge when in_setf. They update even if emask == 00, and otherwise hold.
//  done: registered, high the cycle after "finish", or the cycle after accepting an emask==00 transaction.
//   A new accept in the finish cycle does not suppress done.
//  dst1 == dst2, both enabled: both writes are issued, Y1 then Y2; the register ends holding Y2.
//  Reset (resetn low, any time, including mid-transaction): state IDLE; pending writes discarded; rf_we, rf_waddr, rf_wdata, flags, done, busy = 0; in_ready = 0 while resetn low, 1 after release.
//  No partial writes: a write is either accepted whole by rf_ready or not issued.
// TESTING
//  1. Single write: accept y1=0x1234, dst1=3, wmask=01 -> next cycle rf_we=1, waddr=3, wdata=0x1234; rf_ready=1 -> done pulse next cycle, busy=0.
//  2. Dual write with stall: wmask=11, dst1=4, dst2=5, y1=0xAAAA0000, y2=0x0000BBBB, rf_ready low 3 cycles.
//     -> WR1 held 3 cycles, then addr 5 data 0x0000BBBB, then done. Exactly 2 rf writes total.
//  3. R0 drop: wmask=11, dst1=0, dst2=7 -> only one write (addr 7); dst1=dst2=0 -> no rf_we, done 1 cycle after accept.
//  4. Back-to-back: three 1-word transactions, in_valid held, rf_ready=1.
//     -> rf_we high 3 consecutive cycles, 3 done pulses, in_ready never low after first accept.
//  5. Flags: in_setf=1, in_cmp=0x5A, wmask=00 -> flags=0x5A next cycle. Next transaction with in_setf=0 -> flags stay 0x5A.
//  6. Reset mid-transaction: resetn low during WR1 of a wmask=11 transaction.
//     -> rf_we=0 immediately, flags=0, no done; after release in_ready=1 and no stale write appears.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU result writeback: accepts a (Y1, Y2, compare) transaction and retires it through
// a single register-file write port, one word per cycle, while owning the compare flags.
module alu_writeback #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int FLAG_W  = 8,
  parameter int DROP_R0 = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_y1,
  input  logic [DATA_W-1:0] in_y2,
  input  logic [FLAG_W-1:0] in_cmp,
  input  logic [ADDR_W-1:0] in_dst1,
  input  logic [ADDR_W-1:0] in_dst2,
  input  logic [1:0]        in_wmask,
  input  logic              in_setf,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  output logic [FLAG_W-1:0] flags,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR1  = 2'd1;
  localparam logic [1:0] WR2  = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [DATA_W-1:0] y1_reg, y2_reg;
  logic [ADDR_W-1:0] dst1_reg, dst2_reg;
  logic [1:0]        emask_reg;
  logic [FLAG_W-1:0] flags_reg;
  logic              done_reg, done_next;

  logic              accept;
  logic              finish;
  logic [1:0]        new_emask;
  logic              drop1, drop2;

  // Address 0 is a hardwired zero register when DROP_R0 is set.
  assign drop1     = (DROP_R0 != 0) && (in_dst1 == '0);
  assign drop2     = (DROP_R0 != 0) && (in_dst2 == '0);
  assign new_emask = {in_wmask[1] & ~drop2, in_wmask[0] & ~drop1};

  assign finish   = ((state_reg == WR1) && rf_ready && !emask_reg[1]) ||
                    ((state_reg == WR2) && rf_ready);
  assign in_ready = resetn && ((state_reg == IDLE) || finish);
  assign accept   = in_valid && in_ready;

  // A new accept overrides the finish-to-IDLE transition so back-to-back work has no bubble.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WR1: if (rf_ready) state_next = emask_reg[1] ? WR2 : IDLE;
      WR2: if (rf_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (accept) begin
      if (new_emask[0])      state_next = WR1;
      else if (new_emask[1]) state_next = WR2;
      else                   state_next = IDLE;
    end
  end

  assign done_next = finish || (accept && (new_emask == 2'b00));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      y1_reg    <= '0;
      y2_reg    <= '0;
      dst1_reg  <= '0;
      dst2_reg  <= '0;
      emask_reg <= '0;
      flags_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      if (accept) begin
        y1_reg    <= in_y1;
        y2_reg    <= in_y2;
        dst1_reg  <= in_dst1;
        dst2_reg  <= in_dst2;
        emask_reg <= new_emask;
        if (in_setf) flags_reg <= in_cmp;
      end
    end
  end

  // The write request is a pure function of state, so it stays stable until rf_ready.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state_reg)
      WR1: begin
        rf_we    = 1'b1;
        rf_waddr = dst1_reg;
        rf_wdata = y1_reg;
      end
      WR2: begin
        rf_we    = 1'b1;
        rf_waddr = dst2_reg;
        rf_wdata = y2_reg;
      end
      default: ;
    endcase
  end

  assign flags = flags_reg;
  assign busy  = (state_reg != IDLE);
  assign done  = done_reg;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: table of single transactions plus hand sequences for
// latency, stall, back-to-back and mid-transaction reset.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y1, in_y2;
  logic [7:0]  in_cmp;
  logic [4:0]  in_dst1, in_dst2;
  logic [1:0]  in_wmask;
  logic        in_setf;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ready;
  logic [7:0]  flags;
  logic        busy, done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [4:0]  wa_q[$];
  logic [31:0] wd_q[$];

  localparam logic [63:0] NONE = 64'hDEAD_BEEF_DEAD_BEEF;

  alu_writeback #(.DATA_W(32), .ADDR_W(5), .FLAG_W(8), .DROP_R0(1)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y1(in_y1), .in_y2(in_y2), .in_cmp(in_cmp),
    .in_dst1(in_dst1), .in_dst2(in_dst2), .in_wmask(in_wmask), .in_setf(in_setf),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so the falling edge sees settled handshakes.
  always @(negedge clk) begin
    if (resetn && rf_we && rf_ready) begin
      wa_q.push_back(rf_waddr);
      wd_q.push_back(rf_wdata);
    end
    if (done) done_cnt++;
  end

  typedef struct {
    logic [1:0]  wmask;
    logic [4:0]  dst1, dst2;
    logic [31:0] y1, y2;
    logic        setf;
    logic [7:0]  cmp;
    int          nw;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [7:0]  fl;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wm, input logic [4:0] d1, input logic [4:0] d2,
                       input logic [31:0] y1, input logic [31:0] y2,
                       input logic sf, input logic [7:0] cmp);
    in_valid = 1'b1;
    in_wmask = wm;
    in_dst1  = d1;
    in_dst2  = d2;
    in_y1    = y1;
    in_y2    = y2;
    in_setf  = sf;
    in_cmp   = cmp;
  endtask

  function automatic logic [63:0] qa(input int i);
    return (wa_q.size() > i) ? 64'(wa_q[i]) : NONE;
  endfunction

  function automatic logic [63:0] qd(input int i);
    return (wd_q.size() > i) ? 64'(wd_q[i]) : NONE;
  endfunction

  initial begin
    int dbase;
    logic [4:0] bb_dst[3];
    logic [31:0] bb_y[3];

    //            wmask  dst1   dst2   y1            y2            setf  cmp    nw a0     a1     d0            d1            fl
    vecs[0] = '{2'b01, 5'd3, 5'd0, 32'h0000_1234, 32'h0,        1'b0, 8'h00, 1, 5'd3, 5'd0, 32'h0000_1234, 32'h0,        8'h00};
    vecs[1] = '{2'b10, 5'd1, 5'd9, 32'h1111_1111, 32'h0000_DEAD, 1'b0, 8'h00, 1, 5'd9, 5'd0, 32'h0000_DEAD, 32'h0,        8'h00};
    vecs[2] = '{2'b11, 5'd0, 5'd7, 32'h0BAD_0BAD, 32'h7777_0007, 1'b0, 8'h00, 1, 5'd7, 5'd0, 32'h7777_0007, 32'h0,        8'h00};
    vecs[3] = '{2'b11, 5'd0, 5'd0, 32'h1,         32'h2,         1'b0, 8'h00, 0, 5'd0, 5'd0, 32'h0,         32'h0,        8'h00};
    vecs[4] = '{2'b11, 5'd6, 5'd6, 32'h0000_0001, 32'h0000_0002, 1'b0, 8'h00, 2, 5'd6, 5'd6, 32'h0000_0001, 32'h0000_0002, 8'h00};
    vecs[5] = '{2'b00, 5'd2, 5'd3, 32'h5,         32'h6,         1'b1, 8'h5A, 0, 5'd0, 5'd0, 32'h0,         32'h0,        8'h5A};
    vecs[6] = '{2'b01, 5'd2, 5'd0, 32'hCAFE_F00D, 32'h0,        1'b0, 8'hFF, 1, 5'd2, 5'd0, 32'hCAFE_F00D, 32'h0,        8'h5A};
    vecs[7] = '{2'b10, 5'd4, 5'd0, 32'h9,         32'hA,         1'b1, 8'hC3, 0, 5'd0, 5'd0, 32'h0,         32'h0,        8'hC3};

    resetn = 1'b0;
    rf_ready = 1'b1;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 8'h0);
    in_valid = 1'b0;

    // Reset state
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // First-write latency
    wa_q.delete(); wd_q.delete(); dbase = done_cnt;
    drive(2'b01, 5'd3, 5'd0, 32'h0000_1234, 32'h0, 1'b0, 8'h0);
    tick();
    in_valid = 1'b0;
    chk("lat_rf_we", 64'(rf_we), 64'd1);
    chk("lat_waddr", 64'(rf_waddr), 64'd3);
    chk("lat_wdata", 64'(rf_wdata), 64'h1234);
    chk("lat_busy", 64'(busy), 64'd1);
    tick();
    chk("lat_done", 64'(done), 64'd1);
    chk("lat_busy_end", 64'(busy), 64'd0);
    chk("lat_rf_we_end", 64'(rf_we), 64'd0);
    tick();
    chk("lat_done_pulse", 64'(done), 64'd0);
    $display("txn latency: writes=%0d done=%0d", wa_q.size(), done_cnt - dbase);

    // Table of single transactions, rf_ready always high
    foreach (vecs[i]) begin
      wa_q.delete(); wd_q.delete(); dbase = done_cnt;
      drive(vecs[i].wmask, vecs[i].dst1, vecs[i].dst2, vecs[i].y1, vecs[i].y2,
            vecs[i].setf, vecs[i].cmp);
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      chk($sformatf("v%0d_nw", i), 64'(wa_q.size()), 64'(vecs[i].nw));
      if (vecs[i].nw >= 1) begin
        chk($sformatf("v%0d_a0", i), qa(0), 64'(vecs[i].a0));
        chk($sformatf("v%0d_d0", i), qd(0), 64'(vecs[i].d0));
      end
      if (vecs[i].nw >= 2) begin
        chk($sformatf("v%0d_a1", i), qa(1), 64'(vecs[i].a1));
        chk($sformatf("v%0d_d1", i), qd(1), 64'(vecs[i].d1));
      end
      chk($sformatf("v%0d_done", i), 64'(done_cnt - dbase), 64'd1);
      chk($sformatf("v%0d_flags", i), 64'(flags), 64'(vecs[i].fl));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
      $display("txn v%0d: wmask=%b writes=%0d flags=%h", i, vecs[i].wmask, wa_q.size(), flags);
    end

    // Both lanes dropped: done exactly one cycle after accept
    drive(2'b11, 5'd0, 5'd0, 32'h1, 32'h2, 1'b0, 8'h0);
    tick();
    in_valid = 1'b0;
    chk("r0_done_next", 64'(done), 64'd1);
    chk("r0_no_we", 64'(rf_we), 64'd0);
    tick();
    $display("txn r0r0: done checked one cycle after accept");

    // Dual write with 3-cycle stall
    wa_q.delete(); wd_q.delete(); dbase = done_cnt;
    rf_ready = 1'b0;
    drive(2'b11, 5'd4, 5'd5, 32'hAAAA_0000, 32'h0000_BBBB, 1'b0, 8'h0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_we", k), 64'(rf_we), 64'd1);
      chk($sformatf("stall%0d_addr", k), 64'(rf_waddr), 64'd4);
      chk($sformatf("stall%0d_data", k), 64'(rf_wdata), 64'hAAAA_0000);
      chk($sformatf("stall%0d_in_ready", k), 64'(in_ready), 64'd0);
      tick();
    end
    rf_ready = 1'b1;
    chk("stall_wr1_addr", 64'(rf_waddr), 64'd4);
    tick();
    chk("stall_wr2_we", 64'(rf_we), 64'd1);
    chk("stall_wr2_addr", 64'(rf_waddr), 64'd5);
    chk("stall_wr2_data", 64'(rf_wdata), 64'h0000_BBBB);
    tick();
    chk("stall_done", 64'(done), 64'd1);
    repeat (2) tick();
    chk("stall_nw", 64'(wa_q.size()), 64'd2);
    chk("stall_done_cnt", 64'(done_cnt - dbase), 64'd1);
    $display("txn stall: writes=%0d", wa_q.size());

    // Back-to-back single-word transactions with in_valid held
    wa_q.delete(); wd_q.delete(); dbase = done_cnt;
    bb_dst[0] = 5'd10; bb_dst[1] = 5'd11; bb_dst[2] = 5'd12;
    bb_y[0] = 32'h1000_0001; bb_y[1] = 32'h2000_0002; bb_y[2] = 32'h3000_0003;
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, bb_dst[k], 5'd0, bb_y[k], 32'h0, 1'b0, 8'h0);
      #1;
      chk($sformatf("bb%0d_in_ready", k), 64'(in_ready), 64'd1);
      if (k > 0) begin
        chk($sformatf("bb%0d_we", k), 64'(rf_we), 64'd1);
        chk($sformatf("bb%0d_addr", k), 64'(rf_waddr), 64'(bb_dst[k-1]));
      end
      tick();
    end
    in_valid = 1'b0;
    chk("bb2_we", 64'(rf_we), 64'd1);
    chk("bb2_addr", 64'(rf_waddr), 64'(bb_dst[2]));
    repeat (3) tick();
    chk("bb_nw", 64'(wa_q.size()), 64'd3);
    chk("bb_d2", qd(2), 64'(bb_y[2]));
    chk("bb_done_cnt", 64'(done_cnt - dbase), 64'd3);
    $display("txn b2b: writes=%0d done=%0d", wa_q.size(), done_cnt - dbase);

    // Reset in the middle of WR1
    rf_ready = 1'b0;
    drive(2'b11, 5'd8, 5'd9, 32'h0000_0888, 32'h0000_0999, 1'b1, 8'h33);
    tick();
    in_valid = 1'b0;
    chk("mid_we_before", 64'(rf_we), 64'd1);
    chk("mid_flags_before", 64'(flags), 64'h33);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_we_rst", 64'(rf_we), 64'd0);
    chk("mid_flags_rst", 64'(flags), 64'd0);
    chk("mid_busy_rst", 64'(busy), 64'd0);
    chk("mid_in_ready_rst", 64'(in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    wa_q.delete(); wd_q.delete(); dbase = done_cnt;
    rf_ready = 1'b1;
    chk("mid_in_ready_rel", 64'(in_ready), 64'd1);
    repeat (4) tick();
    chk("mid_no_write", 64'(wa_q.size()), 64'd0);
    chk("mid_no_done", 64'(done_cnt - dbase), 64'd0);
    chk("mid_flags_after", 64'(flags), 64'd0);
    $display("txn reset_mid: writes=%0d done=%0d", wa_q.size(), done_cnt - dbase);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
